// File: rtl/qrd_input_skew_if.sv
// Row handshake and skewed-lane bus for the QRD-RLS input skew stage.
// master = upstream/consumer side, slave = skew stage.
interface qrd_input_skew_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_last;
  logic           frame_done;
  logic [7:0]     err_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid,
    input  out_last, frame_done, err_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid,
    output out_last, frame_done, err_cnt
  );
endinterface

// File: rtl/qrd_input_skew.sv
// Input skew stage for the QRD-RLS systolic array: lane k lags lane 0 by k*STAGE_LAT.
// Optional QRD_SKEW_ERR_EN: saturating count of rows offered while draining.
module qrd_input_skew #(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int STAGE_LAT = 19,
  parameter int ROWS      = 8
) (
  input logic            clk,
  input logic            rst,
  qrd_input_skew_if.slave bus
);
  localparam int DLEN = (N - 1) * STAGE_LAT;
  localparam int DCW  = (DLEN > 1) ? $clog2(DLEN) : 1;
  localparam int RCW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [DCW-1:0] drain_cnt;
  logic [RCW-1:0] row_cnt;
  logic           rdy;
  logic           fdone;
  logic           fdone_n;
  logic           accept;
  logic           is_last;
  logic           acc_last;
  logic           drain_end;

  assign accept    = bus.in_valid & rdy;
  assign is_last   = (row_cnt == RCW'(ROWS - 1));
  assign acc_last  = accept & is_last;
  assign drain_end = (drain_cnt == DCW'(DLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // With a zero-length wedge (N==1) the last row closes the frame at once.
  always_comb begin
    state_n = state;
    fdone_n = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (acc_last) begin
          if (DLEN == 0) begin
            state_n = IDLE;
            fdone_n = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end else if (accept) begin
          state_n = RUN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_n = IDLE;
          fdone_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy       <= 1'b1;
      fdone     <= 1'b0;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      rdy   <= (state_n != DRAIN);
      fdone <= fdone_n;
      if (accept) row_cnt <= is_last ? '0 : row_cnt + 1'b1;
      if (state == DRAIN && state_n == DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.frame_done = fdone;

  // Each lane carries {valid, last, data}; idle cycles inject zeros.
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int D = 1 + k * STAGE_LAT;
    logic [W+1:0] sr [D];
    logic [W+1:0] lane_in;

    assign lane_in = accept ? {1'b1, is_last, bus.in_data[k*W +: W]} : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < D; i++) sr[i] <= '0;
      end else begin
        sr[0] <= lane_in;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    end

    assign bus.out_data[k*W +: W] = sr[D-1][W-1:0];
    assign bus.out_valid[k]       = sr[D-1][W+1];
    assign bus.out_last[k]        = sr[D-1][W];
  end

`ifdef QRD_SKEW_ERR_EN
  logic [7:0] err;

  always_ff @(posedge clk) begin
    if (rst)
      err <= '0;
    else if (bus.in_valid && !rdy && err != 8'hFF)
      err <= err + 8'd1;
  end

  assign bus.err_cnt = err;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_qrd_input_skew.sv
// Scoreboard bench for qrd_input_skew: N=4/L=19/ROWS=8 main DUT plus an N=1/ROWS=1 DUT.
// Expected lane words are queued at drive time and popped when due.
module tb_qrd_input_skew;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int L    = 19;
  localparam int ROWS = 8;
  localparam int DL   = (N - 1) * L;
`ifdef QRD_SKEW_ERR_EN
  localparam int ERR_EXP = 255;
`else
  localparam int ERR_EXP = 0;
`endif

  typedef struct {
    int           due;
    logic         last;
    logic [W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q [N][$];
  int   fd_q [$];
  int   blk_lo = 0;
  int   blk_hi = 0;
  int   row_m = 0;
  int   err_m = 0;
  int   stalls = 0;
  int   last_fd = -1;
  int   acc_cyc = 0;
  logic acc = 1'b0;

  qrd_input_skew_if #(.N(N), .W(W)) bus ();
  qrd_input_skew_if #(.N(1), .W(W)) bus1 ();

  qrd_input_skew #(.N(N), .W(W), .STAGE_LAT(L), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  qrd_input_skew #(.N(1), .W(W), .STAGE_LAT(L), .ROWS(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] row(input int f, input int r);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = W'(32'h1000 * f + 32'h0100 * r + k);
    return v;
  endfunction

  // One cycle: check outputs at the negedge, then drive the next inputs.
  task automatic step(input logic v, input logic [N*W-1:0] d, input logic r);
    logic rdy_m;
    logic fe;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      logic [W+1:0] want;
      want = '0;
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        want = {1'b1, q[k][0].last, q[k][0].d};
        void'(q[k].pop_front());
      end
      check($sformatf("lane%0d", k),
            64'({bus.out_valid[k], bus.out_last[k], bus.out_data[k*W +: W]}),
            64'(want));
    end
    fe = (fd_q.size() > 0 && fd_q[0] == cyc);
    if (fe) void'(fd_q.pop_front());
    check("frame_done", 64'(bus.frame_done), 64'(fe));
    if (bus.frame_done) last_fd = cyc;
    rdy_m = !(cyc >= blk_lo && cyc < blk_hi);
    check("in_ready", 64'(bus.in_ready), 64'(rdy_m));
    check("err_cnt", 64'(bus.err_cnt), 64'(err_m));
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    acc          = 1'b0;
    if (r) begin
      for (int k = 0; k < N; k++) q[k].delete();
      fd_q.delete();
      blk_lo = 0;
      blk_hi = 0;
      row_m  = 0;
      err_m  = 0;
    end else if (v && rdy_m) begin
      acc     = 1'b1;
      acc_cyc = cyc;
      for (int k = 0; k < N; k++) begin
        e.due  = cyc + 1 + k * L;
        e.last = (row_m == ROWS - 1);
        e.d    = d[k*W +: W];
        q[k].push_back(e);
      end
      if (row_m == ROWS - 1) begin
        fd_q.push_back(cyc + 1 + DL);
        blk_lo = cyc + 1;
        blk_hi = cyc + 1 + DL;
        row_m  = 0;
      end else begin
        row_m++;
      end
    end else if (v) begin
      stalls++;
`ifdef QRD_SKEW_ERR_EN
      if (err_m < 255) err_m++;
`endif
    end
  endtask

  task automatic offer(input logic [N*W-1:0] d);
    int n;
    n = 0;
    do begin
      step(1'b1, d, 1'b0);
      n++;
    end while (!acc && n < 200);
    check("offer_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    int c0;
    int qs;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;

    // reset state
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 1: back-to-back frame
    c0 = -1;
    for (int r = 0; r < ROWS; r++) begin
      offer(row(0, r));
      if (r == 0) c0 = acc_cyc;
    end
    idle(DL + 8);
    check("fd_cycle", 64'(last_fd - c0), 64'd65);

    // 2: drain lock, next frame enters in the frame_done cycle
    for (int r = 0; r < ROWS; r++) offer(row(1, r));
    stalls = 0;
    offer(row(2, 0));
    check("drain_stalls", 64'(stalls), 64'(DL));
    check("acc_in_fd_cycle", 64'(acc_cyc), 64'(last_fd));
    for (int r = 1; r < ROWS; r++) offer(row(2, r));
    idle(DL + 8);

    // 3: gapped input
    for (int r = 0; r < ROWS; r++) begin
      offer(row(3, r));
      idle(2);
    end
    idle(DL + 8);

    // 4: reset mid-frame, row counter restarts
    for (int r = 0; r < 5; r++) offer(row(4, r));
    step(1'b0, '0, 1'b1);
    idle(DL + 4);
    for (int r = 0; r < ROWS; r++) offer(row(5, r));
    idle(DL + 8);

    // 5: repeated offers during drain
    for (int f = 0; f < 7; f++)
      for (int r = 0; r < ROWS; r++) offer(row(6 + f, r));
    idle(DL + 8);
    check("err_final", 64'(bus.err_cnt), 64'(ERR_EXP));
    qs = 0;
    for (int k = 0; k < N; k++) qs += q[k].size();
    check("sb_empty", 64'(qs + fd_q.size()), 64'd0);

    // 6: N=1, ROWS=1
    @(negedge clk);
    rst1 = 1'b0;
    check("n1_reset_ready", 64'(bus1.in_ready), 64'd1);
    check("n1_reset_out", 64'({bus1.out_valid, bus1.out_last, bus1.frame_done}), 64'd0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'hBEEF;
    @(negedge clk);
    check("n1_out_a", 64'({bus1.out_valid, bus1.out_last, bus1.frame_done, bus1.out_data}),
          64'({3'b111, 16'hBEEF}));
    check("n1_ready_a", 64'(bus1.in_ready), 64'd1);
    bus1.in_data = 16'h1234;
    @(negedge clk);
    check("n1_out_b", 64'({bus1.out_valid, bus1.out_last, bus1.frame_done, bus1.out_data}),
          64'({3'b111, 16'h1234}));
    check("n1_ready_b", 64'(bus1.in_ready), 64'd1);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("n1_idle", 64'({bus1.out_valid, bus1.out_last, bus1.frame_done, bus1.out_data}),
          64'd0);
    check("n1_err", 64'(bus1.err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
